// File: rtl/det_job_scheduler_pkg.sv
// Shared definitions for the determinant-engine job scheduler.
//  - Matrix / determinant / grant-id widths.
//  - One-hot FSM state encoding.
//  - Grant-id to one-hot helper used for response routing.
package det_job_scheduler_pkg;

  localparam int unsigned MAT_W = 256;  // 64 entries x 4 bits, entry r*8+c at [(r*8+c)*4+:4]
  localparam int unsigned DET_W = 32;   // two's complement determinant
  localparam int unsigned GID_W = 3;    // enough for up to 8 requesters

  typedef enum logic [4:0] {
    StIdle  = 5'b00001,
    StIssue = 5'b00010,
    StWait  = 5'b00100,
    StResp  = 5'b01000,
    StAbort = 5'b10000
  } state_e;

  function automatic logic [7:0] gid_onehot(input logic [GID_W-1:0] gid);
    return 8'b1 << gid;
  endfunction

endpackage

// File: rtl/det_job_scheduler_if.sv
// Bundle of client-side and engine-side signals of the job scheduler.
//  Client side : req, req_mat (in); rsp_valid, rsp_det, rsp_err, busy, grant_id (out)
//  Engine side : eng_mat, eng_Start, eng_Ack, eng_Reset (out); eng_q_Enter, eng_q_Done,
//                eng_det (in)
//  Modport slave is the scheduler's view; master is the view of clients plus engine.
interface det_job_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  import det_job_scheduler_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ*MAT_W-1:0] req_mat;
  logic [NREQ-1:0]       rsp_valid;
  logic [DET_W-1:0]      rsp_det;
  logic                  rsp_err;
  logic                  busy;
  logic [GID_W-1:0]      grant_id;
  logic [MAT_W-1:0]      eng_mat;
  logic                  eng_Start;
  logic                  eng_Ack;
  logic                  eng_Reset;
  logic                  eng_q_Enter;
  logic                  eng_q_Done;
  logic [DET_W-1:0]      eng_det;

  modport slave (
    input  req, req_mat, eng_q_Enter, eng_q_Done, eng_det,
    output rsp_valid, rsp_det, rsp_err, busy, grant_id, eng_mat, eng_Start, eng_Ack, eng_Reset
  );

  modport master (
    output req, req_mat, eng_q_Enter, eng_q_Done, eng_det,
    input  rsp_valid, rsp_det, rsp_err, busy, grant_id, eng_mat, eng_Start, eng_Ack, eng_Reset
  );

endinterface

// File: rtl/det_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//  i_req          : request vector
//  i_last_grant   : index served most recently
//  o_grant_valid  : some request is pending
//  o_grant_id     : first set request searching upward from i_last_grant+1, wrapping
module det_job_scheduler_rr_arbiter
  import det_job_scheduler_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [GID_W-1:0] i_last_grant,
  output logic             o_grant_valid,
  output logic [GID_W-1:0] o_grant_id
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IdxW-1:0] w_idx;

  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_id    = '0;
    w_idx         = '0;
    // k = 1 is the highest-priority slot; the last granted requester comes last (k = NREQ).
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = IdxW'((32'(i_last_grant) + k) % NREQ);
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant_id    = GID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/det_job_scheduler.sv
// Shares one 8x8 determinant engine between NREQ requesters.
//  Clk, Reset : clock and synchronous active-high reset
//  bus        : client request/response and engine handshake signals (slave modport)
// One job in flight at a time: IDLE picks a requester round-robin and latches its matrix,
// ISSUE holds Start until the engine is seen in ENTER, WAIT runs a watchdog until Done,
// RESP/ABORT pulse the response for one cycle.
module det_job_scheduler
  import det_job_scheduler_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input logic                   Clk,
  input logic                   Reset,
  det_job_scheduler_if.slave    bus
);

  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC + 1);

  state_e           r_state, w_state_d;
  logic [GID_W-1:0] r_grant_id, r_last_grant;
  logic [MAT_W-1:0] r_eng_mat;
  logic [DET_W-1:0] r_rsp_det;
  logic             r_rsp_err;
  logic             r_eng_reset;
  logic [TmrW-1:0]  r_timer;

  logic             w_grant_valid;
  logic [GID_W-1:0] w_grant_id;
  logic [MAT_W-1:0] w_sel_mat;
  logic             w_timeout;
  logic             w_rsp;

  det_job_scheduler_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .i_req        (bus.req),
    .i_last_grant (r_last_grant),
    .o_grant_valid(w_grant_valid),
    .o_grant_id   (w_grant_id)
  );

  always_comb begin
    w_sel_mat = '0;
    for (int unsigned n = 0; n < NREQ; n++) begin
      if (w_grant_id == GID_W'(n)) w_sel_mat = bus.req_mat[n*MAT_W +: MAT_W];
    end
  end

  assign w_timeout = (r_timer == TmrW'(TIMEOUT_CYC - 1));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_grant_valid) w_state_d = StIssue;
      StIssue: if (bus.eng_q_Enter) w_state_d = StWait;
      StWait: begin
        // Done takes precedence over a coincident timeout.
        if (bus.eng_q_Done)  w_state_d = StResp;
        else if (w_timeout)  w_state_d = StAbort;
      end
      StResp:  w_state_d = StIdle;
      StAbort: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= StIdle;
      r_grant_id   <= '0;
      r_last_grant <= GID_W'(NREQ - 1);
      r_eng_mat    <= '0;
      r_rsp_det    <= '0;
      r_rsp_err    <= 1'b0;
      r_timer      <= '0;
      r_eng_reset  <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      // Abort leaves the engine in an unknown state; reset it during the ABORT cycle.
      r_eng_reset <= (w_state_d == StAbort);
      unique case (r_state)
        StIdle: begin
          if (w_grant_valid) begin
            r_grant_id <= w_grant_id;
            r_eng_mat  <= w_sel_mat;
          end
        end
        StIssue: if (bus.eng_q_Enter) r_timer <= '0;
        StWait: begin
          r_timer <= r_timer + TmrW'(1);
          if (bus.eng_q_Done) begin
            r_rsp_det <= bus.eng_det;
            r_rsp_err <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_det <= '0;
            r_rsp_err <= 1'b1;
          end
        end
        StResp:  r_last_grant <= r_grant_id;
        StAbort: r_last_grant <= r_grant_id;
        default: ;
      endcase
    end
  end

  assign w_rsp         = (r_state == StResp) || (r_state == StAbort);
  assign bus.rsp_valid = w_rsp ? NREQ'(gid_onehot(r_grant_id)) : '0;
  assign bus.rsp_det   = r_rsp_det;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.busy      = (r_state != StIdle);
  assign bus.grant_id  = r_grant_id;
  assign bus.eng_mat   = r_eng_mat;
  assign bus.eng_Start = (r_state == StIssue);
  assign bus.eng_Ack   = (r_state == StResp);
  assign bus.eng_Reset = r_eng_reset;

endmodule

// File: tb/tb_det_job_scheduler.sv
// Directed bench for det_job_scheduler with a small stub engine.
// The stub returns the product of the diagonal (all test matrices are triangular), takes
// ENG_LAT cycles after accepting Start, and can be told to hang to exercise the watchdog.
module tb_det_job_scheduler;
  import det_job_scheduler_pkg::*;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TMO     = 16;
  localparam int unsigned ENG_LAT = 3;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  det_job_scheduler_if #(.NREQ(NREQ)) bus ();

  det_job_scheduler #(
    .NREQ       (NREQ),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stub engine: 0 = ENTER, 1 = computing, 2 = DONE (held until Ack).
  logic        hang = 1'b0;
  int          e_st = 0;
  int          e_cnt = 0;
  logic [31:0] e_det = '0;

  function automatic logic [31:0] diag_prod(input logic [255:0] m);
    logic signed [31:0] p;
    p = 1;
    for (int r = 0; r < 8; r++) p = p * $signed({28'd0, m[(r*9)*4 +: 4]});
    return p;
  endfunction

  always @(posedge Clk) begin
    if (Reset || bus.eng_Reset) begin
      e_st  <= 0;
      e_cnt <= 0;
    end else begin
      case (e_st)
        0: if (bus.eng_Start) begin
          e_st  <= 1;
          e_cnt <= 0;
          e_det <= diag_prod(bus.eng_mat);
        end
        1: if (!hang) begin
          if (e_cnt == ENG_LAT - 1) e_st <= 2;
          else e_cnt <= e_cnt + 1;
        end
        2: if (bus.eng_Ack) e_st <= 0;
        default: e_st <= 0;
      endcase
    end
  end

  assign bus.eng_q_Enter = (e_st == 0);
  assign bus.eng_q_Done  = (e_st == 2);
  assign bus.eng_det     = e_det;

  function automatic logic [255:0] ident(input logic [3:0] d0);
    logic [255:0] m;
    m = '0;
    for (int r = 0; r < 8; r++) m[(r*9)*4 +: 4] = 4'd1;
    m[3:0] = d0;
    return m;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Steps until rsp_valid is seen (bounded); reports steps taken and whether the engine
  // was in DONE during the cycle just before the response.
  task automatic wait_rsp(output int lat, output logic done_prev);
    logic d;
    lat       = 0;
    done_prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      d = bus.eng_q_Done;
      step();
      lat++;
      if (|bus.rsp_valid) begin
        done_prev = d;
        break;
      end
    end
  endtask

  task automatic do_reset();
    Reset   = 1'b1;
    bus.req = '0;
    step();
    Reset = 1'b0;
  endtask

  int           lat;
  logic         dp;
  int           g;
  int           stray;
  logic [255:0] m6;

  initial begin
    bus.req     = '0;
    bus.req_mat = '0;
    step();
    // Reset state, sampled in the cycle after a Reset cycle.
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_eng_start", bus.eng_Start, 0);
    check("rst_eng_reset", bus.eng_Reset, 1);
    check("rst_det", bus.rsp_det, 0);
    Reset = 1'b0;
    step();
    check("rst_eng_reset_drop", bus.eng_Reset, 0);

    // 1: single request, identity matrix.
    bus.req_mat[1*256 +: 256] = ident(4'd1);
    bus.req = 4'b0010;
    step();
    check("t1_start_latency", bus.eng_Start, 1);
    check("t1_grant_id", bus.grant_id, 1);
    wait_rsp(lat, dp);
    check("t1_rsp_latency", lat, 5);
    check("t1_done_to_rsp", dp, 1);
    check("t1_rsp_valid", bus.rsp_valid, 4'b0010);
    check("t1_det", bus.rsp_det, 1);
    check("t1_err", bus.rsp_err, 0);
    check("t1_ack", bus.eng_Ack, 1);
    bus.req = '0;
    step();
    check("t1_valid_pulse", bus.rsp_valid, 0);
    check("t1_det_hold", bus.rsp_det, 1);
    check("t1_idle", bus.busy, 0);

    // 2: requesters 0 and 2 together; 0 first after reset.
    do_reset();
    bus.req_mat[0*256 +: 256] = ident(4'd2);
    bus.req_mat[2*256 +: 256] = '0;
    bus.req = 4'b0101;
    wait_rsp(lat, dp);
    check("t2_first_valid", bus.rsp_valid, 4'b0001);
    check("t2_first_det", bus.rsp_det, 2);
    bus.req = 4'b0100;
    wait_rsp(lat, dp);
    check("t2_second_valid", bus.rsp_valid, 4'b0100);
    check("t2_second_det", bus.rsp_det, 0);
    bus.req = '0;
    step();

    // 3: all four held; round-robin order 0,1,2,3,0,1.
    do_reset();
    for (int n = 0; n < 4; n++) bus.req_mat[n*256 +: 256] = ident(4'(n + 2));
    bus.req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      g = i % 4;
      wait_rsp(lat, dp);
      check("t3_rr_valid", bus.rsp_valid, 64'(4'b0001 << g));
      check("t3_rr_det", bus.rsp_det, 64'(g + 2));
    end
    bus.req = '0;
    step();

    // 4: engine hangs -> abort after 16 WAIT cycles, then a normal job.
    hang = 1'b1;
    bus.req = 4'b0001;
    wait_rsp(lat, dp);
    check("t4_abort_latency", lat, 18);
    check("t4_abort_valid", bus.rsp_valid, 4'b0001);
    check("t4_abort_err", bus.rsp_err, 1);
    check("t4_abort_det", bus.rsp_det, 0);
    check("t4_eng_reset", bus.eng_Reset, 1);
    check("t4_no_ack", bus.eng_Ack, 0);
    bus.req = '0;
    hang = 1'b0;
    step();
    check("t4_eng_reset_pulse", bus.eng_Reset, 0);
    check("t4_err_hold", bus.rsp_err, 1);
    bus.req_mat[1*256 +: 256] = ident(4'd1);
    bus.req = 4'b0010;
    wait_rsp(lat, dp);
    check("t4_recover_valid", bus.rsp_valid, 4'b0010);
    check("t4_recover_det", bus.rsp_det, 1);
    check("t4_recover_err", bus.rsp_err, 0);
    bus.req = '0;
    step();

    // 5: reset while in WAIT.
    bus.req_mat[0*256 +: 256] = ident(4'd2);
    bus.req = 4'b0001;
    step();
    step();
    check("t5_in_wait_busy", bus.busy, 1);
    check("t5_start_dropped", bus.eng_Start, 0);
    Reset   = 1'b1;
    bus.req = '0;
    step();
    Reset = 1'b0;
    check("t5_busy", bus.busy, 0);
    check("t5_rsp_valid", bus.rsp_valid, 0);
    check("t5_eng_reset", bus.eng_Reset, 1);
    check("t5_det", bus.rsp_det, 0);
    check("t5_grant_id", bus.grant_id, 0);
    check("t5_eng_mat", 64'(bus.eng_mat != '0), 0);
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (|bus.rsp_valid) stray++;
    end
    check("t5_no_stray_rsp", stray, 0);

    // 6: upper-triangular, diagonal {3,2,1,1,1,1,1,2}, off-diagonal filler 5.
    m6 = '0;
    for (int r = 0; r < 8; r++)
      for (int c = r + 1; c < 8; c++) m6[(r*8+c)*4 +: 4] = 4'd5;
    for (int r = 0; r < 8; r++) m6[(r*9)*4 +: 4] = 4'd1;
    m6[(0*9)*4 +: 4] = 4'd3;
    m6[(1*9)*4 +: 4] = 4'd2;
    m6[(7*9)*4 +: 4] = 4'd2;
    bus.req_mat[3*256 +: 256] = m6;
    bus.req = 4'b1000;
    wait_rsp(lat, dp);
    check("t6_valid", bus.rsp_valid, 4'b1000);
    check("t6_det", bus.rsp_det, 12);
    bus.req = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
